exu_dispatch_scheduler: RTL and testbench

- In-order dispatch stage between decode/operand-read and the seven execution-unit slave ports: bypass, sysmanage, bru, alu, mdiv, fpu, lsu.
- Buffers decoded micro-ops in a small FIFO and steers the head entry to the pip_exu_interface master modport selected by its unit code.
- Dispatches at most one op per cycle and stalls on the target unit's full.
- Supports pipeline flush.

---
 rtl/exu_dispatch_scheduler_if.sv | 52 +++++
 rtl/exu_dispatch_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_exu_dispatch_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_dispatch_scheduler_if.sv
// Execution-unit slave port bundle; one master modport per unit,
// each listing only the payload fields that unit consumes.
interface pip_exu_interface #(
  parameter int XLEN = 32
) ();
  logic            valid;
  logic            full;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [XLEN-1:0] pc;
  logic [19:0]     imm20;
  logic [4:0]      imm5;
  logic [4:0]      opcode;
  logic [9:0]      funct;
  logic [7:0]      itag;
  logic [4:0]      frs1index;
  logic [4:0]      frs2index;
  logic [4:0]      frs3index;
  logic            frs1en;
  logic            frs2en;
  logic            frs3en;

  modport bypass_mif (
    output valid, itag, pc, opcode, funct, data1,
    input  full
  );
  modport sysmanage_mif (
    output valid, itag, pc, opcode, funct, data1, imm20,
    input  full
  );
  modport bru_mif (
    output valid, itag, pc, opcode, funct, data1, data2, imm20,
    input  full
  );
  modport alu_mif (
    output valid, itag, opcode, funct, data1, data2, imm20, imm5,
    input  full
  );
  modport mdiv_mif (
    output valid, itag, opcode, funct, data1, data2,
    input  full
  );
  modport fpu_mif (
    output valid, itag, opcode, funct, data1, data2, imm5,
    output frs1index, frs2index, frs3index, frs1en, frs2en, frs3en,
    input  full
  );
  modport lsu_mif (
    output valid, itag, pc, opcode, funct, data1, data2, imm20,
    input  full
  );
endinterface

// File: rtl/exu_dispatch_scheduler.sv
// In-order dispatch FIFO steering micro-ops to seven execution units.
// Optional perf counters enabled by EXU_DISPATCH_PERF_EN.
module exu_dispatch_scheduler #(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH),
  parameter int XLEN  = 32
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            in_unit_i,
  input  logic [XLEN-1:0]       in_data1_i,
  input  logic [XLEN-1:0]       in_data2_i,
  input  logic [XLEN-1:0]       in_pc_i,
  input  logic [19:0]           in_imm20_i,
  input  logic [4:0]            in_imm5_i,
  input  logic [4:0]            in_opcode_i,
  input  logic [9:0]            in_funct_i,
  input  logic [7:0]            in_itag_i,
  input  logic [4:0]            in_frs1index_i,
  input  logic [4:0]            in_frs2index_i,
  input  logic [4:0]            in_frs3index_i,
  input  logic                  in_frs1en_i,
  input  logic                  in_frs2en_i,
  input  logic                  in_frs3en_i,
  pip_exu_interface.bypass_mif    bypass_o,
  pip_exu_interface.sysmanage_mif sysmanage_o,
  pip_exu_interface.bru_mif       bru_o,
  pip_exu_interface.alu_mif       alu_o,
  pip_exu_interface.mdiv_mif      mdiv_o,
  pip_exu_interface.fpu_mif       fpu_o,
  pip_exu_interface.lsu_mif       lsu_o
`ifdef EXU_DISPATCH_PERF_EN
  ,
  output logic [63:0]           perf_dispatch_o,
  output logic [63:0]           perf_stall_o
`endif
);

  typedef struct packed {
    logic [2:0]      unit;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] pc;
    logic [19:0]     imm20;
    logic [4:0]      imm5;
    logic [4:0]      opcode;
    logic [9:0]      funct;
    logic [7:0]      itag;
    logic [4:0]      frs1index;
    logic [4:0]      frs2index;
    logic [4:0]      frs3index;
    logic            frs1en;
    logic            frs2en;
    logic            frs3en;
  } uop_t;

  localparam logic [PTRW:0] CNT_MAX = (PTRW+1)'(DEPTH);

  uop_t            mem_q [DEPTH];
  uop_t            mem_d [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]   count_q, count_d;

  uop_t       in_uop;
  uop_t       head;
  logic [6:0] sel;
  logic [6:0] full_vec;
  logic [6:0] vld;
  logic       has_op;
  logic       sel_full;
  logic       push;
  logic       pop;

  assign in_uop = '{
    unit:      in_unit_i,
    data1:     in_data1_i,
    data2:     in_data2_i,
    pc:        in_pc_i,
    imm20:     in_imm20_i,
    imm5:      in_imm5_i,
    opcode:    in_opcode_i,
    funct:     in_funct_i,
    itag:      in_itag_i,
    frs1index: in_frs1index_i,
    frs2index: in_frs2index_i,
    frs3index: in_frs3index_i,
    frs1en:    in_frs1en_i,
    frs2en:    in_frs2en_i,
    frs3en:    in_frs3en_i
  };

  assign head     = mem_q[rd_ptr_q];
  assign full_vec = {lsu_o.full, fpu_o.full, mdiv_o.full, alu_o.full,
                     bru_o.full, sysmanage_o.full, bypass_o.full};

  // Reserved code 7 falls to bypass so it retires via the exception path
  always_comb begin
    sel = 7'b0;
    unique case (head.unit)
      3'd1:    sel[1] = 1'b1;
      3'd2:    sel[2] = 1'b1;
      3'd3:    sel[3] = 1'b1;
      3'd4:    sel[4] = 1'b1;
      3'd5:    sel[5] = 1'b1;
      3'd6:    sel[6] = 1'b1;
      default: sel[0] = 1'b1;
    endcase
  end

  assign in_ready_o = (count_q < CNT_MAX);
  assign has_op     = (count_q != '0) && !flush_i;
  assign vld        = has_op ? sel : 7'b0;
  assign sel_full   = |(sel & full_vec);
  assign pop        = has_op && !sel_full;
  assign push       = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_uop;
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef EXU_DISPATCH_PERF_EN
  logic [63:0] perf_dispatch_q, perf_dispatch_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_dispatch_d = perf_dispatch_q + {63'b0, pop};
    perf_stall_d    = perf_stall_q + {63'b0, has_op && sel_full};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      perf_dispatch_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_dispatch_q <= perf_dispatch_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_dispatch_o = perf_dispatch_q;
  assign perf_stall_o    = perf_stall_q;
`endif

  assign bypass_o.valid  = vld[0];
  assign bypass_o.itag   = head.itag;
  assign bypass_o.pc     = head.pc;
  assign bypass_o.opcode = head.opcode;
  assign bypass_o.funct  = head.funct;
  assign bypass_o.data1  = head.data1;

  assign sysmanage_o.valid  = vld[1];
  assign sysmanage_o.itag   = head.itag;
  assign sysmanage_o.pc     = head.pc;
  assign sysmanage_o.opcode = head.opcode;
  assign sysmanage_o.funct  = head.funct;
  assign sysmanage_o.data1  = head.data1;
  assign sysmanage_o.imm20  = head.imm20;

  assign bru_o.valid  = vld[2];
  assign bru_o.itag   = head.itag;
  assign bru_o.pc     = head.pc;
  assign bru_o.opcode = head.opcode;
  assign bru_o.funct  = head.funct;
  assign bru_o.data1  = head.data1;
  assign bru_o.data2  = head.data2;
  assign bru_o.imm20  = head.imm20;

  assign alu_o.valid  = vld[3];
  assign alu_o.itag   = head.itag;
  assign alu_o.opcode = head.opcode;
  assign alu_o.funct  = head.funct;
  assign alu_o.data1  = head.data1;
  assign alu_o.data2  = head.data2;
  assign alu_o.imm20  = head.imm20;
  assign alu_o.imm5   = head.imm5;

  assign mdiv_o.valid  = vld[4];
  assign mdiv_o.itag   = head.itag;
  assign mdiv_o.opcode = head.opcode;
  assign mdiv_o.funct  = head.funct;
  assign mdiv_o.data1  = head.data1;
  assign mdiv_o.data2  = head.data2;

  assign fpu_o.valid     = vld[5];
  assign fpu_o.itag      = head.itag;
  assign fpu_o.opcode    = head.opcode;
  assign fpu_o.funct     = head.funct;
  assign fpu_o.data1     = head.data1;
  assign fpu_o.data2     = head.data2;
  assign fpu_o.imm5      = head.imm5;
  assign fpu_o.frs1index = head.frs1index;
  assign fpu_o.frs2index = head.frs2index;
  assign fpu_o.frs3index = head.frs3index;
  assign fpu_o.frs1en    = head.frs1en;
  assign fpu_o.frs2en    = head.frs2en;
  assign fpu_o.frs3en    = head.frs3en;

  assign lsu_o.valid  = vld[6];
  assign lsu_o.itag   = head.itag;
  assign lsu_o.pc     = head.pc;
  assign lsu_o.opcode = head.opcode;
  assign lsu_o.funct  = head.funct;
  assign lsu_o.data1  = head.data1;
  assign lsu_o.data2  = head.data2;
  assign lsu_o.imm20  = head.imm20;

endmodule

// File: tb/tb_exu_dispatch_scheduler.sv
// Scoreboard bench for exu_dispatch_scheduler: ordering, stalls,
// flush, reset, reserved-unit routing and optional perf counters.
module tb_exu_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  in_unit_i = '0;
  logic [31:0] in_data1_i = '0;
  logic [31:0] in_data2_i = '0;
  logic [31:0] in_pc_i = '0;
  logic [19:0] in_imm20_i = '0;
  logic [4:0]  in_imm5_i = '0;
  logic [4:0]  in_opcode_i = '0;
  logic [9:0]  in_funct_i = '0;
  logic [7:0]  in_itag_i = '0;
  logic [4:0]  in_frs1index_i = '0;
  logic [4:0]  in_frs2index_i = '0;
  logic [4:0]  in_frs3index_i = '0;
  logic        in_frs1en_i = 1'b0;
  logic        in_frs2en_i = 1'b0;
  logic        in_frs3en_i = 1'b0;
`ifdef EXU_DISPATCH_PERF_EN
  logic [63:0] perf_dispatch_o;
  logic [63:0] perf_stall_o;
`endif

  pip_exu_interface #(.XLEN(32)) byp_if ();
  pip_exu_interface #(.XLEN(32)) sys_if ();
  pip_exu_interface #(.XLEN(32)) bru_if ();
  pip_exu_interface #(.XLEN(32)) alu_if ();
  pip_exu_interface #(.XLEN(32)) mdiv_if ();
  pip_exu_interface #(.XLEN(32)) fpu_if ();
  pip_exu_interface #(.XLEN(32)) lsu_if ();

  exu_dispatch_scheduler #(.DEPTH(4), .XLEN(32)) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_unit_i      (in_unit_i),
    .in_data1_i     (in_data1_i),
    .in_data2_i     (in_data2_i),
    .in_pc_i        (in_pc_i),
    .in_imm20_i     (in_imm20_i),
    .in_imm5_i      (in_imm5_i),
    .in_opcode_i    (in_opcode_i),
    .in_funct_i     (in_funct_i),
    .in_itag_i      (in_itag_i),
    .in_frs1index_i (in_frs1index_i),
    .in_frs2index_i (in_frs2index_i),
    .in_frs3index_i (in_frs3index_i),
    .in_frs1en_i    (in_frs1en_i),
    .in_frs2en_i    (in_frs2en_i),
    .in_frs3en_i    (in_frs3en_i),
    .bypass_o       (byp_if),
    .sysmanage_o    (sys_if),
    .bru_o          (bru_if),
    .alu_o          (alu_if),
    .mdiv_o         (mdiv_if),
    .fpu_o          (fpu_if),
    .lsu_o          (lsu_if)
`ifdef EXU_DISPATCH_PERF_EN
    ,
    .perf_dispatch_o(perf_dispatch_o),
    .perf_stall_o   (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] itag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] disp_itag[$];
  int         disp_cyc[$];
  int         disp_port[$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;

  logic [6:0]  v;
  logic [6:0]  f;
  logic [7:0]  tg [7];
  logic [31:0] d1 [7];

  assign v = {lsu_if.valid, fpu_if.valid, mdiv_if.valid, alu_if.valid,
              bru_if.valid, sys_if.valid, byp_if.valid};
  assign f = {lsu_if.full, fpu_if.full, mdiv_if.full, alu_if.full,
              bru_if.full, sys_if.full, byp_if.full};
  assign tg[0] = byp_if.itag;
  assign tg[1] = sys_if.itag;
  assign tg[2] = bru_if.itag;
  assign tg[3] = alu_if.itag;
  assign tg[4] = mdiv_if.itag;
  assign tg[5] = fpu_if.itag;
  assign tg[6] = lsu_if.itag;
  assign d1[0] = byp_if.data1;
  assign d1[1] = sys_if.data1;
  assign d1[2] = bru_if.data1;
  assign d1[3] = alu_if.data1;
  assign d1[4] = mdiv_if.data1;
  assign d1[5] = fpu_if.data1;
  assign d1[6] = lsu_if.data1;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers happen at the next rising edge when valid && !full here
  always @(negedge clk) begin
    if (!srst_i) begin
      n_total++;
      if ($countones(v) > 1) begin
        $display("FAIL onehot_valid: valids=%b, required at most one set", v);
      end else begin
        n_pass++;
      end
      for (int i = 0; i < 7; i++) begin
        if (v[i] && !f[i]) begin
          exp_t e;
          n_total++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_dispatch: port %0d itag %h, required none", i, tg[i]);
          end else begin
            e = sb.pop_front();
            if (e.port != i || tg[i] !== e.itag ||
                d1[i] !== {24'hA5A5A5, e.itag}) begin
              $display("FAIL dispatch: port %0d itag %h data1 %h, required port %0d itag %h data1 %h",
                       i, tg[i], d1[i], e.port, e.itag, {24'hA5A5A5, e.itag});
            end else begin
              n_pass++;
            end
          end
          disp_itag.push_back(tg[i]);
          disp_cyc.push_back(cyc);
          disp_port.push_back(i);
        end
      end
    end
  end

  task automatic clear_log();
    disp_itag.delete();
    disp_cyc.delete();
    disp_port.delete();
  endtask

  task automatic set_full(input logic [6:0] m);
    byp_if.full  = m[0];
    sys_if.full  = m[1];
    bru_if.full  = m[2];
    alu_if.full  = m[3];
    mdiv_if.full = m[4];
    fpu_if.full  = m[5];
    lsu_if.full  = m[6];
  endtask

  task automatic drive_op(input logic [2:0] u, input logic [7:0] t);
    in_valid_i     = 1'b1;
    in_unit_i      = u;
    in_itag_i      = t;
    in_data1_i     = {24'hA5A5A5, t};
    in_data2_i     = {t, 24'h5A5A5A};
    in_pc_i        = {16'h8000, t, 8'h00};
    in_imm20_i     = {12'h0, t};
    in_imm5_i      = t[4:0];
    in_opcode_i    = t[4:0];
    in_funct_i     = {2'b0, t};
    in_frs1index_i = t[4:0];
    in_frs2index_i = t[4:0];
    in_frs3index_i = t[4:0];
    in_frs1en_i    = t[0];
    in_frs2en_i    = t[1];
    in_frs3en_i    = t[2];
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the push edge
  task automatic push(input logic [2:0] u, input logic [7:0] t, input bit exp);
    exp_t e;
    drive_op(u, t);
    if (exp) begin
      e.port = (u == 3'd7) ? 0 : int'(u);
      e.itag = t;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_ready: got %b, required 1", in_ready_o);
    else n_pass++;
    n_total++;
    if (v !== 7'b0) $display("FAIL reset_valids: got %b, required 0000000", v);
    else n_pass++;
    n_total++;
    if (dut.count_q !== 3'd0) $display("FAIL reset_count: got %0d, required 0", dut.count_q);
    else n_pass++;
  endtask

  task automatic test_single_alu();
    @(posedge clk);
    #1;
    clear_log();
    push(3'd3, 8'h10, 1'b1);
    @(negedge clk);
    n_total++;
    if (v !== 7'b0001000 || tg[3] !== 8'h10)
      $display("FAIL alu_first: valids %b itag %h, required 0001000 itag 10", v, tg[3]);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (dut.count_q !== 3'd0 || v !== 7'b0)
      $display("FAIL alu_drain: count %0d valids %b, required 0 and 0000000", dut.count_q, v);
    else n_pass++;
  endtask

  task automatic test_mdiv_full();
    @(posedge clk);
    #1;
    set_full(7'b0010000);
    for (int i = 1; i <= 4; i++) push(3'd4, 8'(i), 1'b1);
    @(negedge clk);
    n_total++;
    if (in_ready_o !== 1'b0) $display("FAIL fifo_full_ready: got %b, required 0", in_ready_o);
    else n_pass++;
    @(posedge clk);
    #1;
    push(3'd4, 8'h55, 1'b0);
    @(negedge clk);
    n_total++;
    if (in_ready_o !== 1'b0 || dut.count_q !== 3'd4)
      $display("FAIL refused_push: ready %b count %0d, required 0 and 4", in_ready_o, dut.count_q);
    else n_pass++;
    @(posedge clk);
    #1;
    clear_log();
    set_full(7'b0);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (disp_itag.size() != 4) begin
      $display("FAIL mdiv_count: got %0d dispatches, required 4", disp_itag.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (disp_itag[i] !== 8'(i + 1) || disp_cyc[i] != disp_cyc[0] + i)
          $display("FAIL mdiv_order[%0d]: itag %h cyc %0d, required itag %h cyc %0d",
                   i, disp_itag[i], disp_cyc[i], 8'(i + 1), disp_cyc[0] + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_in_order();
    @(posedge clk);
    #1;
    set_full(7'b0100000);
    clear_log();
    push(3'd5, 8'h05, 1'b1);
    push(3'd3, 8'h06, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (alu_if.valid !== 1'b0 || fpu_if.valid !== 1'b1)
        $display("FAIL head_block[%0d]: alu %b fpu %b, required 0 and 1",
                 k, alu_if.valid, fpu_if.valid);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    set_full(7'b0);
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (disp_itag.size() != 2) begin
      $display("FAIL in_order_count: got %0d, required 2", disp_itag.size());
    end else if (disp_itag[0] !== 8'h05 || disp_itag[1] !== 8'h06 ||
                 disp_port[0] != 5 || disp_port[1] != 3 ||
                 disp_cyc[1] != disp_cyc[0] + 1) begin
      $display("FAIL in_order: itags %h,%h ports %0d,%0d dcyc %0d, required 05,06 5,3 1",
               disp_itag[0], disp_itag[1], disp_port[0], disp_port[1],
               disp_cyc[1] - disp_cyc[0]);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_flush();
    @(posedge clk);
    #1;
    set_full(7'b1000000);
    push(3'd6, 8'h21, 1'b0);
    push(3'd6, 8'h22, 1'b0);
    push(3'd6, 8'h23, 1'b0);
    clear_log();
    set_full(7'b0);
    flush_i = 1'b1;
    drive_op(3'd3, 8'h09);
    @(negedge clk);
    n_total++;
    if (v !== 7'b0) $display("FAIL flush_valids: got %b, required 0000000", v);
    else n_pass++;
    n_total++;
    if (in_ready_o !== 1'b1) $display("FAIL flush_ready: got %b, required 1", in_ready_o);
    else n_pass++;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (dut.count_q !== 3'd0 || v !== 7'b0)
      $display("FAIL flush_clear: count %0d valids %b, required 0 and 0000000", dut.count_q, v);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (disp_itag.size() != 0) $display("FAIL flush_drop: got %0d dispatches, required 0", disp_itag.size());
    else n_pass++;
  endtask

  task automatic test_bypass7();
    @(posedge clk);
    #1;
    push(3'd7, 8'h7F, 1'b1);
    @(negedge clk);
    n_total++;
    if (v !== 7'b0000001 || tg[0] !== 8'h7F)
      $display("FAIL unit7_bypass: valids %b itag %h, required 0000001 itag 7f", v, tg[0]);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstall();
    @(posedge clk);
    #1;
    set_full(7'b0001000);
    push(3'd3, 8'h31, 1'b0);
    push(3'd3, 8'h32, 1'b0);
    clear_log();
    srst_i = 1'b1;
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    set_full(7'b0);
    @(negedge clk);
    n_total++;
    if (v !== 7'b0 || in_ready_o !== 1'b1 || dut.count_q !== 3'd0)
      $display("FAIL midstall_reset: valids %b ready %b count %0d, required 0000000 1 0",
               v, in_ready_o, dut.count_q);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (disp_itag.size() != 0) $display("FAIL midstall_drop: got %0d dispatches, required 0", disp_itag.size());
    else n_pass++;
  endtask

`ifdef EXU_DISPATCH_PERF_EN
  task automatic test_perf();
    @(posedge clk);
    #1;
    srst_i = 1'b1;
    set_full(7'b0001000);
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    push(3'd3, 8'h41, 1'b1);
    push(3'd3, 8'h42, 1'b1);
    push(3'd3, 8'h43, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    set_full(7'b0);
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (perf_dispatch_o !== 64'd3) $display("FAIL perf_dispatch: got %0d, required 3", perf_dispatch_o);
    else n_pass++;
    n_total++;
    if (perf_stall_o !== 64'd5) $display("FAIL perf_stall: got %0d, required 5", perf_stall_o);
    else n_pass++;
    srst_i = 1'b1;
    @(posedge clk);
    #1;
    srst_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (perf_dispatch_o !== 64'd0 || perf_stall_o !== 64'd0)
      $display("FAIL perf_reset: got %0d/%0d, required 0/0", perf_dispatch_o, perf_stall_o);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_full(7'b0);
    test_reset();
    test_single_alu();
    test_mdiv_full();
    test_in_order();
    test_flush();
    test_bypass7();
    test_reset_midstall();
`ifdef EXU_DISPATCH_PERF_EN
    test_perf();
`endif
    @(posedge clk);
    #1;
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
